tl_a_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one TileLink-UL master port between N requesters.
- Sits upstream of the TL monitor point on the shared link, so everything it drives is checked by the existing monitor.
- Holds the grant across multi-beat Put bursts and across stalled beats, so the A channel stays stable once valid.
- Tags each request's source with the requester index and routes D-channel responses back by that tag.

---
 rtl/tl_arb_pkg.sv | 37 +++
 rtl/rr_pick.sv | 34 +++
 rtl/tl_a_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_tl_a_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_arb_pkg.sv
// -----------------------------------------------------------------------------
// tl_arb_pkg: shared definitions for the TileLink-UL A-channel arbiters.
//   - TL-UL A-channel opcode constants
//   - arb_state_e : arbiter FSM state encoding
//   - beats_of()  : number of A-channel beats a request occupies
// -----------------------------------------------------------------------------
package tl_arb_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] ARITH       = 3'd2;
    localparam logic [2:0] LOGIC       = 3'd3;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] HINT        = 3'd5;

    // Largest burst is 16 beats, so the remaining-beat counter is 4 bits.
    localparam int unsigned BEAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        BURST
    } arb_state_e;

    // Only Puts carry data on A, so only they can span several beats.
    function automatic logic [4:0] beats_of(input logic [2:0]  opcode,
                                            input logic [2:0]  size,
                                            input int unsigned data_w);
        int unsigned lg;
        lg       = $clog2(data_w / 8);
        beats_of = 5'd1;
        if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) && 32'(size) > lg) begin
            beats_of = 5'(1 << (32'(size) - lg));
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: combinational N-way round-robin priority selector.
//   valid : request vector
//   ptr   : highest-priority index this cycle
//   idx   : first valid index at or after ptr, wrapping modulo N
//           (equals ptr when nothing is valid)
//   any   : at least one request is valid
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!any && valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/tl_a_port_arbiter.sv
// -----------------------------------------------------------------------------
// tl_a_port_arbiter: shares one TileLink-UL master port between N requesters.
//   clock, reset           : sole clock, synchronous active-high reset
//   in_a_*  (packed x N)   : per-requester A channels
//   out_a_*                : shared A channel; out_a_source = {grant, source}
//   out_d_*                : shared D channel from the slave side
//   in_d_*                 : D channel fanned back; valid steered by the
//                            requester index in out_d_source's top bits
// The A payload is a pure mux on the grant (zero latency). The grant is held
// while a request stalls and across every beat of a multi-beat Put.
// -----------------------------------------------------------------------------
module tl_a_port_arbiter
    import tl_arb_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned SRC_W  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned IDX_W  = $clog2(N),
    localparam int unsigned MASK_W = DATA_W / 8
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic [N-1:0]             in_a_valid,
    output logic [N-1:0]             in_a_ready,
    input  logic [N*3-1:0]           in_a_opcode,
    input  logic [N*3-1:0]           in_a_param,
    input  logic [N*3-1:0]           in_a_size,
    input  logic [N*SRC_W-1:0]       in_a_source,
    input  logic [N*ADDR_W-1:0]      in_a_address,
    input  logic [N*MASK_W-1:0]      in_a_mask,
    input  logic [N*DATA_W-1:0]      in_a_data,

    output logic                     out_a_valid,
    input  logic                     out_a_ready,
    output logic [2:0]               out_a_opcode,
    output logic [2:0]               out_a_param,
    output logic [2:0]               out_a_size,
    output logic [SRC_W+IDX_W-1:0]   out_a_source,
    output logic [ADDR_W-1:0]        out_a_address,
    output logic [MASK_W-1:0]        out_a_mask,
    output logic [DATA_W-1:0]        out_a_data,

    input  logic                     out_d_valid,
    output logic                     out_d_ready,
    input  logic [2:0]               out_d_opcode,
    input  logic [2:0]               out_d_size,
    input  logic [SRC_W+IDX_W-1:0]   out_d_source,
    input  logic [DATA_W-1:0]        out_d_data,

    output logic [N-1:0]             in_d_valid,
    input  logic [N-1:0]             in_d_ready,
    output logic [2:0]               in_d_opcode,
    output logic [2:0]               in_d_size,
    output logic [SRC_W-1:0]         in_d_source,
    output logic [DATA_W-1:0]        in_d_data
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]       pick;
    logic                   pick_any;
    logic [IDX_W-1:0]       grant;
    logic [SRC_W-1:0]       src_sel;
    logic [4:0]             beats;
    logic                   fire;
    logic [IDX_W-1:0]       d_idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (32'(i) == N - 1) begin
            next_idx = '0;
        end else begin
            next_idx = i + 1'b1;
        end
    endfunction

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .valid (in_a_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick),
        .any   (pick_any)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (fire) begin
                    rr_ptr_d = next_idx(grant);
                    if (beats > 5'd1) begin
                        state_d    = BURST;
                        grant_d    = grant;
                        // First beat fires now; count the ones still to come minus one.
                        beat_cnt_d = BEAT_CNT_W'(beats - 5'd2);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (out_a_valid) begin
                    // Stalled: freeze the grant so the A payload stays stable.
                    state_d = HOLD;
                    grant_d = grant;
                end
            end
            BURST: begin
                if (fire) begin
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs: grant, valid, ready ----------------
    always_comb begin
        grant       = grant_q;
        out_a_valid = 1'b0;
        if (state_q == IDLE) begin
            grant       = pick;
            out_a_valid = pick_any;
        end else begin
            // Frozen grant: a dropped valid is passed through, not re-arbitrated.
            out_a_valid = in_a_valid[grant_q];
        end
        if (reset) begin
            out_a_valid = 1'b0;
        end
        in_a_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDX_W'(i)) begin
                in_a_ready[i] = out_a_ready && !reset;
            end
        end
    end

    assign fire = out_a_valid && out_a_ready;

    // ---------------- A payload mux ----------------
    always_comb begin
        out_a_opcode  = '0;
        out_a_param   = '0;
        out_a_size    = '0;
        src_sel       = '0;
        out_a_address = '0;
        out_a_mask    = '0;
        out_a_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDX_W'(i)) begin
                out_a_opcode  = in_a_opcode[3*i +: 3];
                out_a_param   = in_a_param[3*i +: 3];
                out_a_size    = in_a_size[3*i +: 3];
                src_sel       = in_a_source[SRC_W*i +: SRC_W];
                out_a_address = in_a_address[ADDR_W*i +: ADDR_W];
                out_a_mask    = in_a_mask[MASK_W*i +: MASK_W];
                out_a_data    = in_a_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign out_a_source = {grant, src_sel};
    assign beats        = beats_of(out_a_opcode, out_a_size, DATA_W);

    // ---------------- D routing (stateless) ----------------
    assign d_idx = out_d_source[SRC_W +: IDX_W];

    always_comb begin
        in_d_valid = '0;
        // Responses tagged with a nonexistent requester are drained.
        out_d_ready = !reset;
        for (int i = 0; i < N; i++) begin
            if (d_idx == IDX_W'(i)) begin
                in_d_valid[i] = out_d_valid && !reset;
                out_d_ready   = in_d_ready[i] && !reset;
            end
        end
    end

    assign in_d_opcode = out_d_opcode;
    assign in_d_size   = out_d_size;
    assign in_d_source = out_d_source[SRC_W-1:0];
    assign in_d_data   = out_d_data;

endmodule

// File: tb/tb_tl_a_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_a_port_arbiter: directed bench for tl_a_port_arbiter (N=2), plus a
// small N=3 instance used only to exercise out-of-range D routing.
// A transaction-level model (owner / beats left / priority pointer) predicts
// the shared outputs every cycle; directed steps also check literal values.
// -----------------------------------------------------------------------------
module tb_tl_a_port_arbiter;

    localparam int N = 2;

    logic         clock = 1'b0;
    logic         reset;

    logic [1:0]   in_a_valid, in_a_ready;
    logic [5:0]   in_a_opcode, in_a_param, in_a_size;
    logic [7:0]   in_a_source;
    logic [63:0]  in_a_address;
    logic [15:0]  in_a_mask;
    logic [127:0] in_a_data;
    logic         out_a_valid, out_a_ready;
    logic [2:0]   out_a_opcode, out_a_param, out_a_size;
    logic [4:0]   out_a_source;
    logic [31:0]  out_a_address;
    logic [7:0]   out_a_mask;
    logic [63:0]  out_a_data;
    logic         out_d_valid, out_d_ready;
    logic [2:0]   out_d_opcode, out_d_size;
    logic [4:0]   out_d_source;
    logic [63:0]  out_d_data;
    logic [1:0]   in_d_valid, in_d_ready;
    logic [2:0]   in_d_opcode, in_d_size;
    logic [3:0]   in_d_source;
    logic [63:0]  in_d_data;

    // N=3 instance signals
    logic [2:0]   n3_in_a_ready, n3_in_d_valid, n3_in_d_ready;
    logic         n3_out_a_valid, n3_out_d_valid, n3_out_d_ready;
    logic [2:0]   n3_out_a_opcode, n3_out_a_param, n3_out_a_size;
    logic [5:0]   n3_out_a_source, n3_out_d_source;
    logic [31:0]  n3_out_a_address;
    logic [7:0]   n3_out_a_mask;
    logic [63:0]  n3_out_a_data, n3_in_d_data;
    logic [2:0]   n3_in_d_opcode, n3_in_d_size;
    logic [3:0]   n3_in_d_source;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int   m_ptr, m_owner, m_left;
    logic m_locked;

    always #5 clock = ~clock;

    tl_a_port_arbiter #(.N(2), .SRC_W(4), .ADDR_W(32), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
        .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
        .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
        .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
        .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data)
    );

    tl_a_port_arbiter #(.N(3), .SRC_W(4), .ADDR_W(32), .DATA_W(64)) dut3 (
        .clock(clock), .reset(reset),
        .in_a_valid(3'b000), .in_a_ready(n3_in_a_ready), .in_a_opcode(9'd0),
        .in_a_param(9'd0), .in_a_size(9'd0), .in_a_source(12'd0),
        .in_a_address(96'd0), .in_a_mask(24'd0), .in_a_data(192'd0),
        .out_a_valid(n3_out_a_valid), .out_a_ready(1'b0), .out_a_opcode(n3_out_a_opcode),
        .out_a_param(n3_out_a_param), .out_a_size(n3_out_a_size),
        .out_a_source(n3_out_a_source), .out_a_address(n3_out_a_address),
        .out_a_mask(n3_out_a_mask), .out_a_data(n3_out_a_data),
        .out_d_valid(n3_out_d_valid), .out_d_ready(n3_out_d_ready), .out_d_opcode(3'd1),
        .out_d_size(3'd3), .out_d_source(n3_out_d_source), .out_d_data(64'h0),
        .in_d_valid(n3_in_d_valid), .in_d_ready(n3_in_d_ready), .in_d_opcode(n3_in_d_opcode),
        .in_d_size(n3_in_d_size), .in_d_source(n3_in_d_source), .in_d_data(n3_in_d_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [2:0] sz, input logic [3:0] src,
                           input logic [31:0] addr);
        in_a_valid[i]          = v;
        in_a_opcode[3*i +: 3]  = op;
        in_a_param[3*i +: 3]   = 3'd0;
        in_a_size[3*i +: 3]    = sz;
        in_a_source[4*i +: 4]  = src;
        in_a_address[32*i +: 32] = addr;
        in_a_mask[8*i +: 8]    = 8'hFF;
        in_a_data[64*i +: 64]  = {addr, ~addr};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    function automatic int beats(input logic [2:0] op, input logic [2:0] sz);
        if (op >= 3'd2 || sz <= 3'd3) return 1;
        return 1 << (int'(sz) - 3);
    endfunction

    // Who the model says owns the shared A channel right now, and whether A is valid.
    task automatic model_grant(output int g, output logic v);
        g = m_ptr;
        v = 1'b0;
        if (m_locked) begin
            g = m_owner;
            v = in_a_valid[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!v && in_a_valid[(m_ptr + k) % N]) begin
                    g = (m_ptr + k) % N;
                    v = 1'b1;
                end
            end
        end
    endtask

    // model update
    always @(posedge clock) begin
        int   g, n;
        logic v;
        if (reset) begin
            m_ptr = 0; m_owner = 0; m_left = 0; m_locked = 1'b0;
        end else begin
            model_grant(g, v);
            if (v && out_a_ready) begin
                if (m_left == 0) begin
                    n        = beats(in_a_opcode[3*g +: 3], in_a_size[3*g +: 3]);
                    m_ptr    = (g + 1) % N;
                    m_owner  = g;
                    m_left   = n - 1;
                    m_locked = (n > 1);
                end else begin
                    m_left   = m_left - 1;
                    m_locked = (m_left > 0);
                end
            end else if (v && !m_locked) begin
                m_locked = 1'b1;
                m_owner  = g;
                m_left   = 0;
            end
        end
    end

    // compare against model
    always @(negedge clock) begin
        int   g, di;
        logic v;
        if (reset) begin
            check("rst_out_a_valid", 64'(out_a_valid), 64'd0);
            check("rst_in_a_ready", 64'(in_a_ready), 64'd0);
            check("rst_out_d_ready", 64'(out_d_ready), 64'd0);
            check("rst_in_d_valid", 64'(in_d_valid), 64'd0);
        end else begin
            model_grant(g, v);
            check("m_out_a_valid", 64'(out_a_valid), 64'(v));
            if (v) begin
                check("m_out_a_source", 64'(out_a_source), 64'((g << 4) | int'(in_a_source[4*g +: 4])));
                check("m_out_a_address", 64'(out_a_address), 64'(in_a_address[32*g +: 32]));
                check("m_out_a_data", out_a_data, in_a_data[64*g +: 64]);
                check("m_out_a_opcode", 64'(out_a_opcode), 64'(in_a_opcode[3*g +: 3]));
            end
            if (!out_a_ready) begin
                check("m_in_a_ready", 64'(in_a_ready), 64'd0);
            end else if (m_locked || v) begin
                check("m_in_a_ready", 64'(in_a_ready), 64'(1 << g));
            end
            di = int'(out_d_source[4]);
            check("m_in_d_valid", 64'(in_d_valid), out_d_valid ? 64'(1 << di) : 64'd0);
            check("m_out_d_ready", 64'(out_d_ready), 64'(in_d_ready[di]));
            check("m_in_d_source", 64'(in_d_source), 64'(out_d_source[3:0]));
            check("m_in_d_data", in_d_data, out_d_data);
        end
    end

    initial begin
        reset = 1'b1;
        in_a_valid = '0; in_a_opcode = '0; in_a_param = '0; in_a_size = '0;
        in_a_source = '0; in_a_address = '0; in_a_mask = '0; in_a_data = '0;
        out_d_opcode = 3'd1; out_d_size = 3'd3; out_d_data = 64'hDEAD_BEEF_0000_0001;
        n3_out_d_valid = 1'b0; n3_out_d_source = '0; n3_in_d_ready = '0;
        // Drive everything active during reset so the gating is actually tested.
        set_req(0, 1'b1, 3'd4, 3'd3, 4'h5, 32'h1000);
        set_req(1, 1'b1, 3'd4, 3'd3, 4'hA, 32'h2000);
        out_a_ready = 1'b1; out_d_valid = 1'b1; out_d_source = 5'h13; in_d_ready = 2'b11;
        step(); step();
        settle();
        check("reset_out_a_valid", 64'(out_a_valid), 64'd0);
        check("reset_in_a_ready", 64'(in_a_ready), 64'd0);
        check("reset_out_d_ready", 64'(out_d_ready), 64'd0);
        check("reset_in_d_valid", 64'(in_d_valid), 64'd0);

        // Two simultaneous Gets: req0 then req1.
        step();
        reset = 1'b0; out_d_valid = 1'b0;
        settle();
        check("rr_first_source", 64'(out_a_source), 64'h05);
        check("rr_first_ready", 64'(in_a_ready), 64'h1);
        step(); settle();
        check("rr_second_source", 64'(out_a_source), 64'h1A);
        check("rr_second_ready", 64'(in_a_ready), 64'h2);

        // req0 4-beat PutFull while req1 waits with a Get.
        step();
        set_req(0, 1'b1, 3'd0, 3'd5, 4'h5, 32'h1100);
        set_req(1, 1'b1, 3'd4, 3'd3, 4'hA, 32'h2000);
        for (int b = 0; b < 4; b++) begin
            settle();
            check("burst_beat_ready", 64'(in_a_ready), 64'h1);
            check("burst_beat_source", 64'(out_a_source), 64'h05);
            step();
        end
        in_a_valid[0] = 1'b0;
        settle();
        check("after_burst_source", 64'(out_a_source), 64'h1A);
        check("after_burst_ready", 64'(in_a_ready), 64'h2);

        // Stall with req1 granted; req0 arriving later must not steal the grant.
        step();
        in_a_valid = 2'b10; out_a_ready = 1'b0;
        settle();
        check("hold_c0_source", 64'(out_a_source), 64'h1A);
        step();
        set_req(0, 1'b1, 3'd4, 3'd2, 4'h5, 32'h1200);
        settle();
        check("hold_c1_source", 64'(out_a_source), 64'h1A);
        check("hold_c1_address", 64'(out_a_address), 64'h2000);
        check("hold_c1_ready", 64'(in_a_ready), 64'h0);
        step(); settle();
        check("hold_c2_address", 64'(out_a_address), 64'h2000);
        step();
        out_a_ready = 1'b1;
        settle();
        check("hold_fire_source", 64'(out_a_source), 64'h1A);
        check("hold_fire_ready", 64'(in_a_ready), 64'h2);
        step();
        in_a_valid[1] = 1'b0;
        settle();
        check("post_hold_source", 64'(out_a_source), 64'h05);
        step();
        in_a_valid = 2'b00;

        // D AccessAckData, two beats to requester 1, source 3.
        out_d_valid = 1'b1; out_d_source = 5'h13; in_d_ready = 2'b10;
        settle();
        check("d_in_d_valid", 64'(in_d_valid), 64'h2);
        check("d_in_d_source", 64'(in_d_source), 64'h3);
        check("d_out_d_ready", 64'(out_d_ready), 64'h1);
        step();
        in_d_ready = 2'b01;
        settle();
        check("d_stall_ready", 64'(out_d_ready), 64'h0);
        check("d_stall_valid", 64'(in_d_valid), 64'h2);
        step();
        out_d_valid = 1'b0;

        // Reset in the middle of a 4-beat burst.
        set_req(0, 1'b1, 3'd0, 3'd5, 4'h5, 32'h1300);
        settle();
        check("rb_beat1_ready", 64'(in_a_ready), 64'h1);
        step(); settle();
        check("rb_beat2_ready", 64'(in_a_ready), 64'h1);
        step();
        reset = 1'b1;
        settle();
        check("rb_reset_valid", 64'(out_a_valid), 64'h0);
        check("rb_reset_ready", 64'(in_a_ready), 64'h0);
        step();
        reset = 1'b0;
        in_a_valid = 2'b10;
        settle();
        check("rb_only1_source", 64'(out_a_source), 64'h1A);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_a_valid = 2'b11;
        settle();
        check("rb_both_source", 64'(out_a_source), 64'h05);
        check("rb_both_ready", 64'(in_a_ready), 64'h1);
        step();
        in_a_valid = 2'b00;

        // Out-of-range D index on the N=3 instance.
        n3_out_d_valid = 1'b1; n3_out_d_source = {2'd2, 4'h1}; n3_in_d_ready = 3'b000;
        settle();
        check("n3_idx2_valid", 64'(n3_in_d_valid), 64'h4);
        check("n3_idx2_ready", 64'(n3_out_d_ready), 64'h0);
        step();
        n3_out_d_source = {2'd3, 4'h1};
        settle();
        check("n3_idx3_valid", 64'(n3_in_d_valid), 64'h0);
        check("n3_idx3_ready", 64'(n3_out_d_ready), 64'h1);
        step();
        n3_out_d_valid = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
